stream_demux3: RTL and testbench

Registered 1-to-3 stream demultiplexer: the routing counterpart of the team's 3-input select mux. A single valid/ready input stream carries a 2-bit select; each accepted word is delivered to one of three independent valid/ready output ports through a one-entry output register. The unused select code 2'b11 is fully covered: the word is dropped, flagged and counted, never latched or routed, so pre- and post-synthesis behaviour match.

---
 rtl/stream_demux3.sv | 124 ++++++++++++
 tb/tb_stream_demux3.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/stream_demux3.sv
// stream_demux3: registered 1-to-3 valid/ready stream demultiplexer.
// Each accepted word is routed by in_sel to a one-entry output register on
// port 0..2. The code 2'b11 drops the word, pulses err_pulse, sets err_sticky
// and bumps a saturating drop counter.
module stream_demux3 #(
    parameter int W     = 8,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_sel,
    input  logic [W-1:0]       in_data,
    output logic [2:0]         out_valid,
    input  logic [2:0]         out_ready,
    output logic [3*W-1:0]     out_data,
    output logic               err_pulse,
    output logic               err_sticky,
    input  logic               err_clr,
    output logic [CNT_W-1:0]   drop_cnt
);

    // Per-port state: full flag and payload register.
    logic [2:0]       v_q, v_d;
    logic [W-1:0]     d_q [3];
    logic [W-1:0]     d_d [3];

    // Error / drop bookkeeping.
    logic             err_pulse_q, err_pulse_d;
    logic             err_sticky_q, err_sticky_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    // Decoded select and handshake terms.
    logic [2:0]       sel_oh;
    logic             accept;
    logic             illegal;

    // Full parallel select decode; code 3 maps to "no port".
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves
        // it unassigned; an unassigned path would infer a latch.
        sel_oh = 3'b000;
        case (in_sel)
            2'd0:    sel_oh = 3'b001;
            2'd1:    sel_oh = 3'b010;
            2'd2:    sel_oh = 3'b100;
            default: sel_oh = 3'b000;
        endcase
    end

    // Ready is per destination: a full port only stalls words aimed at it.
    always_comb begin
        if (sel_oh == 3'b000) begin
            in_ready = 1'b1;
        end else begin
            in_ready = |(sel_oh & (~v_q | out_ready));
        end
        accept  = in_valid & in_ready;
        illegal = accept & (sel_oh == 3'b000);
    end

    // Next-state logic: per-port load/drain and the drop/error bookkeeping.
    always_comb begin
        v_d          = v_q;
        d_d          = d_q;
        err_pulse_d  = illegal;
        err_sticky_d = err_sticky_q;
        drop_cnt_d   = drop_cnt_q;

        for (int k = 0; k < 3; k++) begin
            // A load on the same edge as a drain wins, keeping the port full.
            if (accept && sel_oh[k]) begin
                v_d[k] = 1'b1;
                d_d[k] = in_data;
            end else if (v_q[k] && out_ready[k]) begin
                v_d[k] = 1'b0;
            end
        end

        // Set has priority over clear so a drop is never lost to err_clr.
        if (illegal) begin
            err_sticky_d = 1'b1;
        end else if (err_clr) begin
            err_sticky_d = 1'b0;
        end

        if (illegal && (drop_cnt_q != {CNT_W{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            v_q          <= 3'b000;
            // NOTE: payload registers are reset too because out_data must read
            // zero after reset; they are flops, not a memory array.
            for (int k = 0; k < 3; k++) begin
                d_q[k] <= '0;
            end
            err_pulse_q  <= 1'b0;
            err_sticky_q <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            v_q          <= v_d;
            for (int k = 0; k < 3; k++) begin
                d_q[k] <= d_d[k];
            end
            err_pulse_q  <= err_pulse_d;
            err_sticky_q <= err_sticky_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign out_valid  = v_q;
    assign out_data   = {d_q[2], d_q[1], d_q[0]};
    assign err_pulse  = err_pulse_q;
    assign err_sticky = err_sticky_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_stream_demux3.sv
// tb_stream_demux3: directed scenarios plus randomized traffic, all checked
// against a queue-based behavioural model of three capacity-one ports.
module tb_stream_demux3;

    localparam int W     = 8;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         in_sel;
    logic [W-1:0]       in_data;
    logic [2:0]         out_valid;
    logic [2:0]         out_ready;
    logic [3*W-1:0]     out_data;
    logic               err_pulse;
    logic               err_sticky;
    logic               err_clr;
    logic [CNT_W-1:0]   drop_cnt;

    stream_demux3 #(.W(W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .err_pulse  (err_pulse),
        .err_sticky (err_sticky),
        .err_clr    (err_clr),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: each port is a queue holding at most one word;
    // last_d is the payload the port register shows (last word routed there).
    logic [W-1:0] port_q [3][$];
    logic [W-1:0] last_d [3];
    int           m_drops;
    bit           m_sticky;
    bit           m_pulse;
    bit           last_accept;

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            port_q[k].delete();
            last_d[k] = '0;
        end
        m_drops  = 0;
        m_sticky = 0;
        m_pulse  = 0;
    endtask

    // One clock: check all outputs at the falling edge, advance the model,
    // then return 1 time unit after the rising edge.
    task automatic step();
        bit exp_ready;
        bit acc;
        @(negedge clk);
        if (in_sel == 2'd3) exp_ready = 1'b1;
        else exp_ready = (port_q[in_sel].size() == 0) || out_ready[in_sel];
        check("in_ready", in_ready, exp_ready);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("out_valid%0d", k), out_valid[k], port_q[k].size() > 0);
            check($sformatf("out_data%0d", k), out_data[k*W +: W],
                  (port_q[k].size() > 0) ? port_q[k][0] : last_d[k]);
        end
        check("err_pulse", err_pulse, m_pulse);
        check("err_sticky", err_sticky, m_sticky);
        check("drop_cnt", drop_cnt, (m_drops > CMAX) ? CMAX : m_drops);

        acc = in_valid && exp_ready;
        last_accept = acc && !rst;
        if (rst) begin
            model_reset();
        end else begin
            for (int k = 0; k < 3; k++)
                if (out_ready[k] && port_q[k].size() > 0) void'(port_q[k].pop_front());
            m_pulse = acc && (in_sel == 2'd3);
            if (acc && in_sel != 2'd3) begin
                port_q[in_sel].push_back(in_data);
                last_d[in_sel] = in_data;
            end
            if (m_pulse) begin
                m_drops++;
                m_sticky = 1;
            end else if (err_clr) begin
                m_sticky = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [1:0] s, input logic [W-1:0] d,
                         input logic [2:0] ordy, input bit clr);
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = ordy;
        err_clr   = clr;
        step();
    endtask

    initial begin
        bit          pending;
        logic [1:0]  p_sel;
        logic [W-1:0] p_data;
        int          pulses;

        rst = 1'b1; in_valid = 0; in_sel = 0; in_data = 0; out_ready = 0; err_clr = 0;
        @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;
        check("rst_out_valid", out_valid, 3'b000);
        check("rst_drop_cnt", drop_cnt, 0);

        // Three words to three ports on consecutive cycles.
        drive(1, 2'd0, 8'hA1, 3'b111, 0);
        check("s1_v0", out_valid, 3'b001);
        drive(1, 2'd1, 8'hB2, 3'b111, 0);
        check("s1_v1", out_valid, 3'b010);
        check("s1_d1", out_data[15:8], 8'hB2);
        drive(1, 2'd2, 8'hC3, 3'b111, 0);
        check("s1_v2", out_valid, 3'b100);
        check("s1_d2", out_data[23:16], 8'hC3);
        drive(0, 2'd0, 8'h00, 3'b111, 0);
        check("s1_idle", out_valid, 3'b000);

        // Port 1 backpressure, then simultaneous drain and load.
        drive(1, 2'd1, 8'h11, 3'b101, 0);
        drive(1, 2'd1, 8'h22, 3'b101, 0);
        check("s2_hold", out_data[15:8], 8'h11);
        check("s2_ready_low", in_ready, 1'b0);
        drive(1, 2'd1, 8'h22, 3'b111, 0);
        check("s2_v1", out_valid[1], 1'b1);
        check("s2_d1", out_data[15:8], 8'h22);
        drive(0, 2'd0, 8'h00, 3'b111, 0);

        // Stalled port 0 does not block port 2.
        drive(1, 2'd0, 8'h44, 3'b000, 0);
        drive(1, 2'd2, 8'h33, 3'b000, 0);
        check("s3_v", out_valid, 3'b101);
        check("s3_d0", out_data[7:0], 8'h44);
        check("s3_d2", out_data[23:16], 8'h33);
        drive(0, 2'd0, 8'h00, 3'b111, 0);

        // Illegal select: drop, flag, count; clear; clear coincident with drop.
        drive(1, 2'd3, 8'hEE, 3'b111, 0);
        check("s4_pulse", err_pulse, 1'b1);
        check("s4_sticky", err_sticky, 1'b1);
        check("s4_cnt", drop_cnt, 1);
        check("s4_v", out_valid, 3'b000);
        drive(0, 2'd0, 8'h00, 3'b111, 1);
        check("s4_clr", err_sticky, 1'b0);
        check("s4_pulse_end", err_pulse, 1'b0);
        drive(1, 2'd3, 8'hEF, 3'b111, 1);
        check("s4_set_wins", err_sticky, 1'b1);
        check("s4_cnt2", drop_cnt, 2);
        drive(0, 2'd0, 8'h00, 3'b111, 1);

        // Randomized traffic obeying the valid/ready hold rule.
        pending = 0; p_sel = 0; p_data = 0;
        for (int i = 0; i < 2000; i++) begin
            if (!pending || last_accept) begin
                pending = ($urandom_range(0, 9) < 7);
                p_sel   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                p_data  = W'($urandom);
            end
            rst = ($urandom_range(0, 199) == 0);
            if (rst) pending = 0;
            in_valid  = pending;
            in_sel    = p_sel;
            in_data   = p_data;
            out_ready = {$urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6,
                         $urandom_range(0, 9) < 6};
            err_clr   = ($urandom_range(0, 9) == 0);
            step();
        end
        rst = 0;

        // Saturation: 260 consecutive drops.
        pulses = 0;
        for (int i = 0; i < 260; i++) begin
            drive(1, 2'd3, W'(i), 3'b111, 0);
            if (err_pulse === 1'b1) pulses++;
        end
        check("sat_cnt", drop_cnt, CMAX);
        check("sat_pulses", pulses, 260);
        drive(0, 2'd0, 8'h00, 3'b111, 0);

        // Reset with every port full and stalled.
        drive(1, 2'd0, 8'h5A, 3'b000, 0);
        drive(1, 2'd1, 8'h6B, 3'b000, 0);
        drive(1, 2'd2, 8'h7C, 3'b000, 0);
        check("r_full", out_valid, 3'b111);
        rst = 1;
        drive(0, 2'd0, 8'h00, 3'b000, 0);
        rst = 0;
        check("r_v", out_valid, 3'b000);
        check("r_data", out_data, 0);
        check("r_cnt", drop_cnt, 0);
        check("r_sticky", err_sticky, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 2'd0, 8'h00, 3'b111, 0);
            check("r_no_emit", out_valid, 3'b000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
